// File: rtl/ra_bist_march_32x32_pkg.sv
// Shared definitions for the 32x32 register-array March C- BIST engine:
// element codes, FSM states, status-word bit positions.
package ra_bist_march_32x32_pkg;

  localparam int ADR_W_DEF  = 5;
  localparam int DAT_W_DEF  = 32;
  localparam int FAIL_CNT_W = 8;

  localparam logic [2:0] ELEM_M0 = 3'd0;
  localparam logic [2:0] ELEM_M1 = 3'd1;
  localparam logic [2:0] ELEM_M2 = 3'd2;
  localparam logic [2:0] ELEM_M3 = 3'd3;
  localparam logic [2:0] ELEM_M4 = 3'd4;
  localparam logic [2:0] ELEM_M5 = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_M0   = 4'd1,
    S_M1   = 4'd2,
    S_M2   = 4'd3,
    S_M3   = 4'd4,
    S_M4   = 4'd5,
    S_M5   = 4'd6,
    S_CHK  = 4'd7,
    S_DONE = 4'd8
  } state_e;

  localparam logic PH_RD = 1'b0;
  localparam logic PH_WR = 1'b1;

  localparam int ST_ACTIVE   = 0;
  localparam int ST_DONE     = 1;
  localparam int ST_FAIL     = 2;
  localparam int ST_ELEM_LSB = 3;
  localparam int ST_ADR_LSB  = 6;
  localparam int ST_CNT_LSB  = 11;
  localparam int ST_PORT     = 19;

  function automatic logic [2:0] elem_of(state_e s);
    case (s)
      S_M1:    return ELEM_M1;
      S_M2:    return ELEM_M2;
      S_M3:    return ELEM_M3;
      S_M4:    return ELEM_M4;
      S_M5:    return ELEM_M5;
      default: return ELEM_M0;
    endcase
  endfunction

  function automatic logic [31:0] pack_status(
    logic active, logic done, logic fail, logic [2:0] elem,
    logic [4:0] adr, logic [FAIL_CNT_W-1:0] cnt, logic port);
    logic [31:0] s;
    s = '0;
    s[ST_ACTIVE]                  = active;
    s[ST_DONE]                    = done;
    s[ST_FAIL]                    = fail;
    s[ST_ELEM_LSB +: 3]           = elem;
    s[ST_ADR_LSB +: 5]            = adr;
    s[ST_CNT_LSB +: FAIL_CNT_W]   = cnt;
    s[ST_PORT]                    = port;
    return s;
  endfunction

endpackage

// File: rtl/ra_bist_march_32x32_if.sv
// BIST-side port bundle between the March engine (master) and the array mux (slave).
// Handshake: each *_enb is a single-cycle strobe qualifying its address/data in
// that cycle; read data returns exactly one cycle after a read strobe; no back-pressure.
interface ra_bist_march_32x32_if #(
  parameter int ADR_W = 5,
  parameter int DAT_W = 32
);
  logic             bist_rd0_enb;
  logic [ADR_W-1:0] bist_rd0_adr;
  logic             bist_rd1_enb;
  logic [ADR_W-1:0] bist_rd1_adr;
  logic             bist_wr0_enb;
  logic [ADR_W-1:0] bist_wr0_adr;
  logic [DAT_W-1:0] bist_wr0_dat;
  logic [DAT_W-1:0] rd0_dat;
  logic [DAT_W-1:0] rd1_dat;

  modport master (
    output bist_rd0_enb, bist_rd0_adr, bist_rd1_enb, bist_rd1_adr,
    output bist_wr0_enb, bist_wr0_adr, bist_wr0_dat,
    input  rd0_dat, rd1_dat
  );

  modport slave (
    input  bist_rd0_enb, bist_rd0_adr, bist_rd1_enb, bist_rd1_adr,
    input  bist_wr0_enb, bist_wr0_adr, bist_wr0_dat,
    output rd0_dat, rd1_dat
  );
endinterface

// File: rtl/ra_bist_march_32x32_addr_gen.sv
// Up/down address counter for the March engine: load-to-0 / load-to-max,
// and a terminal flag for the current direction (max going up, 0 going down).
module ra_bist_march_32x32_addr_gen #(
  parameter int ADR_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load_zero,
  input  logic             i_load_max,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic             i_down,
  output logic [ADR_W-1:0] o_adr,
  output logic             o_term
);
  logic [ADR_W-1:0] r_adr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_adr <= '0;
    end else if (i_load_zero) begin
      r_adr <= '0;
    end else if (i_load_max) begin
      r_adr <= '1;
    end else if (i_inc) begin
      r_adr <= r_adr + 1'b1;
    end else if (i_dec) begin
      r_adr <= r_adr - 1'b1;
    end
  end

  assign o_adr  = r_adr;
  assign o_term = i_down ? (r_adr == '0) : (r_adr == '1);
endmodule

// File: rtl/ra_bist_march_32x32.sv
// March C- BIST engine for the 32x32 SDR register array (2R/1W).
// Optional build macro RA_BIST_STOP_ON_FAIL_EN: end the run on the first miscompare.
module ra_bist_march_32x32
  import ra_bist_march_32x32_pkg::*;
#(
  parameter int ADR_W = ADR_W_DEF,
  parameter int DAT_W = DAT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic [DAT_W-1:0]      i_bg,
  ra_bist_march_32x32_if.master bist,
  output logic                  o_active,
  output logic                  o_done,
  output logic                  o_fail,
  output logic                  o_passed,
  output logic [2:0]            o_fail_elem,
  output logic [ADR_W-1:0]      o_fail_adr,
  output logic                  o_fail_port,
  output logic [FAIL_CNT_W-1:0] o_fail_cnt,
  output logic [31:0]           o_status,
  output state_e                o_dbg_state
);
  state_e                r_state, w_state_nxt;
  logic                  r_phase, w_phase_nxt;
  logic [DAT_W-1:0]      r_bg;
  logic                  r_cmp_vld;
  logic [ADR_W-1:0]      r_cmp_adr;
  logic [DAT_W-1:0]      r_cmp_exp;
  logic [2:0]            r_cmp_elem;
  logic                  r_fail;
  logic [2:0]            r_fail_elem;
  logic [ADR_W-1:0]      r_fail_adr;
  logic                  r_fail_port;
  logic [FAIL_CNT_W-1:0] r_fail_cnt;

  logic                  w_active, w_start_acc;
  logic                  w_rd_en, w_wr_en;
  logic [DAT_W-1:0]      w_wr_dat, w_exp;
  logic                  w_ld_zero, w_ld_max, w_inc, w_dec, w_down;
  logic [ADR_W-1:0]      w_adr;
  logic                  w_term;
  logic                  w_mis0, w_mis1, w_any_mis;
  logic [1:0]            w_mis_amt;
  logic [FAIL_CNT_W:0]   w_cnt_sum;
  logic                  w_elem_a;

  ra_bist_march_32x32_addr_gen #(.ADR_W(ADR_W)) u_addr_gen (
    .clk         (clk),
    .reset       (reset),
    .i_load_zero (w_ld_zero),
    .i_load_max  (w_ld_max),
    .i_inc       (w_inc),
    .i_dec       (w_dec),
    .i_down      (w_down),
    .o_adr       (w_adr),
    .o_term      (w_term)
  );

  assign w_active    = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_start_acc = i_start && !w_active;
  // M1/M3 read "0" and write "1"; M2/M4 the reverse
  assign w_elem_a    = (r_state == S_M1) || (r_state == S_M3);

  // Compares are pipelined one cycle behind the read that produced the data.
  assign w_mis0    = w_active && r_cmp_vld && (bist.rd0_dat != r_cmp_exp);
  assign w_mis1    = w_active && r_cmp_vld && (bist.rd1_dat != r_cmp_exp);
  assign w_any_mis = w_mis0 || w_mis1;
  assign w_mis_amt = {1'b0, w_mis0} + {1'b0, w_mis1};
  assign w_cnt_sum = {1'b0, r_fail_cnt} + {{(FAIL_CNT_W-1){1'b0}}, w_mis_amt};

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_rd_en     = 1'b0;
    w_wr_en     = 1'b0;
    w_wr_dat    = '0;
    w_exp       = '0;
    w_ld_zero   = 1'b0;
    w_ld_max    = 1'b0;
    w_inc       = 1'b0;
    w_dec       = 1'b0;
    w_down      = (r_state == S_M3) || (r_state == S_M4);
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_state_nxt = S_M0;
          w_phase_nxt = PH_RD;
          w_ld_zero   = 1'b1;
        end
      end
      S_M0: begin
        w_wr_en  = 1'b1;
        w_wr_dat = r_bg;
        if (w_term) begin
          w_state_nxt = S_M1;
          w_ld_zero   = 1'b1;
        end else begin
          w_inc = 1'b1;
        end
      end
      S_M1, S_M2, S_M3, S_M4: begin
        if (r_phase == PH_RD) begin
          w_rd_en     = 1'b1;
          w_exp       = w_elem_a ? r_bg : ~r_bg;
          w_phase_nxt = PH_WR;
        end else begin
          w_wr_en     = 1'b1;
          w_wr_dat    = w_elem_a ? ~r_bg : r_bg;
          w_phase_nxt = PH_RD;
          if (w_term) begin
            case (r_state)
              S_M1:    begin w_state_nxt = S_M2; w_ld_zero = 1'b1; end
              S_M2:    begin w_state_nxt = S_M3; w_ld_max  = 1'b1; end
              S_M3:    begin w_state_nxt = S_M4; w_ld_max  = 1'b1; end
              default: begin w_state_nxt = S_M5; w_ld_zero = 1'b1; end
            endcase
          end else if (w_down) begin
            w_dec = 1'b1;
          end else begin
            w_inc = 1'b1;
          end
        end
      end
      S_M5: begin
        w_rd_en = 1'b1;
        w_exp   = r_bg;
        if (w_term) begin
          w_state_nxt = S_CHK;
        end else begin
          w_inc = 1'b1;
        end
      end
      S_CHK:   w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
`ifdef RA_BIST_STOP_ON_FAIL_EN
    if (w_any_mis) begin
      w_state_nxt = S_DONE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_phase     <= PH_RD;
      r_bg        <= '0;
      r_cmp_vld   <= 1'b0;
      r_cmp_adr   <= '0;
      r_cmp_exp   <= '0;
      r_cmp_elem  <= ELEM_M0;
      r_fail      <= 1'b0;
      r_fail_elem <= '0;
      r_fail_adr  <= '0;
      r_fail_port <= 1'b0;
      r_fail_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_phase    <= w_phase_nxt;
      r_cmp_vld  <= w_rd_en;
      r_cmp_adr  <= w_adr;
      r_cmp_exp  <= w_exp;
      r_cmp_elem <= elem_of(r_state);
      if (w_start_acc) begin
        r_bg        <= i_bg;
        r_fail      <= 1'b0;
        r_fail_elem <= '0;
        r_fail_adr  <= '0;
        r_fail_port <= 1'b0;
        r_fail_cnt  <= '0;
      end else if (w_any_mis) begin
        r_fail_cnt <= w_cnt_sum[FAIL_CNT_W] ? '1 : w_cnt_sum[FAIL_CNT_W-1:0];
        if (!r_fail) begin
          r_fail      <= 1'b1;
          r_fail_elem <= r_cmp_elem;
          r_fail_adr  <= r_cmp_adr;
          r_fail_port <= !w_mis0;
        end
      end
    end
  end

  assign bist.bist_rd0_enb = w_rd_en;
  assign bist.bist_rd0_adr = w_rd_en ? w_adr : '0;
  assign bist.bist_rd1_enb = w_rd_en;
  assign bist.bist_rd1_adr = w_rd_en ? w_adr : '0;
  assign bist.bist_wr0_enb = w_wr_en;
  assign bist.bist_wr0_adr = w_wr_en ? w_adr : '0;
  assign bist.bist_wr0_dat = w_wr_dat;

  assign o_active    = w_active;
  assign o_done      = (r_state == S_DONE);
  assign o_fail      = r_fail;
  assign o_passed    = o_done && !r_fail;
  assign o_fail_elem = r_fail_elem;
  assign o_fail_adr  = r_fail_adr;
  assign o_fail_port = r_fail_port;
  assign o_fail_cnt  = r_fail_cnt;
  assign o_status    = pack_status(w_active, o_done, r_fail, r_fail_elem,
                                   r_fail_adr, r_fail_cnt, r_fail_port);
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_ra_bist_march_32x32.sv
// Self-checking bench for ra_bist_march_32x32: array model with stuck-at read faults,
// March-level reference model, table-driven runs, reset/start corner cases, random runs.
module tb_ra_bist_march_32x32;
  import ra_bist_march_32x32_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_start;
  logic [31:0] i_bg;
  logic        o_active, o_done, o_fail, o_passed, o_fail_port;
  logic [2:0]  o_fail_elem;
  logic [4:0]  o_fail_adr;
  logic [7:0]  o_fail_cnt;
  logic [31:0] o_status;
  state_e      o_dbg_state;

  always #5 clk = ~clk;

  ra_bist_march_32x32_if #(.ADR_W(5), .DAT_W(32)) bif ();

  ra_bist_march_32x32 dut (
    .clk         (clk),
    .reset       (reset),
    .i_start     (i_start),
    .i_bg        (i_bg),
    .bist        (bif.master),
    .o_active    (o_active),
    .o_done      (o_done),
    .o_fail      (o_fail),
    .o_passed    (o_passed),
    .o_fail_elem (o_fail_elem),
    .o_fail_adr  (o_fail_adr),
    .o_fail_port (o_fail_port),
    .o_fail_cnt  (o_fail_cnt),
    .o_status    (o_status),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- array model with read-side stuck-at fault ----------------
  logic [31:0] mem [32];
  logic        f0_en, f1_en, f_sa1;
  logic [4:0]  f_adr;
  int          f_bit;

  function automatic logic [31:0] faulty(logic [31:0] v, logic en, logic [4:0] a);
    logic [31:0] m;
    m = 32'h1 << f_bit;
    if (en && a == f_adr) return f_sa1 ? (v | m) : (v & ~m);
    return v;
  endfunction

  always @(posedge clk) begin
    if (bif.bist_wr0_enb) mem[bif.bist_wr0_adr] <= bif.bist_wr0_dat;
    if (bif.bist_rd0_enb) bif.rd0_dat <= faulty(mem[bif.bist_rd0_adr], f0_en, bif.bist_rd0_adr);
    if (bif.bist_rd1_enb) bif.rd1_dat <= faulty(mem[bif.bist_rd1_adr], f1_en, bif.bist_rd1_adr);
  end

  // ---------------- scoreboard ----------------
  // per-cycle access: {rd0_en, rd0_adr, rd1_en, rd1_adr, wr_en, wr_adr, wr_dat}
  logic [49:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [49:0] op_r(logic [4:0] a);
    return {1'b1, a, 1'b1, a, 1'b0, 5'd0, 32'd0};
  endfunction

  function automatic logic [49:0] op_w(logic [4:0] a, logic [31:0] d);
    return {1'b0, 5'd0, 1'b0, 5'd0, 1'b1, a, d};
  endfunction

  // ---------------- March-level reference model ----------------
  logic       m_fail, m_port;
  logic [2:0] m_elem;
  logic [4:0] m_adr;
  int         m_cnt, m_len, m_first_cyc, m_first_n;

  task automatic score(input int e, input logic [4:0] a, input logic [31:0] v, input int cyc);
    int n0, n1;
    n0 = (faulty(v, f0_en, a) != v) ? 1 : 0;
    n1 = (faulty(v, f1_en, a) != v) ? 1 : 0;
    if (n0 + n1 > 0) begin
      m_cnt = (m_cnt + n0 + n1 > 255) ? 255 : m_cnt + n0 + n1;
      if (!m_fail) begin
        m_fail = 1'b1; m_elem = 3'(e); m_adr = a; m_port = (n0 == 0);
        m_first_cyc = cyc; m_first_n = n0 + n1;
      end
    end
  endtask

  task automatic build_model(input logic [31:0] bg);
    int cyc;
    logic [4:0] a;
    cyc = 0;
    exp_q.delete();
    m_fail = 1'b0; m_port = 1'b0; m_elem = 3'd0; m_adr = 5'd0; m_cnt = 0;
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < 32; k++) begin
        a = (e == 3 || e == 4) ? 5'(31 - k) : 5'(k);
        if (e == 0) begin
          exp_q.push_back(op_w(a, bg)); cyc++;
        end else begin
          exp_q.push_back(op_r(a)); cyc++;
          score(e, a, (e == 2 || e == 4) ? ~bg : bg, cyc);
          if (e != 5) begin
            exp_q.push_back(op_w(a, (e == 1 || e == 3) ? ~bg : bg)); cyc++;
          end
        end
      end
    end
    exp_q.push_back('0); cyc++;
    m_len = cyc;
`ifdef RA_BIST_STOP_ON_FAIL_EN
    if (m_fail) begin
      while (exp_q.size() > m_first_cyc + 1) void'(exp_q.pop_back());
      m_len = m_first_cyc + 1;
      m_cnt = m_first_n;
    end
`endif
  endtask

  function automatic logic [49:0] observe();
    return {bif.bist_rd0_enb, bif.bist_rd0_adr, bif.bist_rd1_enb, bif.bist_rd1_adr,
            bif.bist_wr0_enb, bif.bist_wr0_adr, bif.bist_wr0_dat};
  endfunction

  task automatic run(input logic [31:0] bg, input int ign_start_cyc);
    int cyc;
    logic [49:0] exp;
    logic [7:0]  cnt8;
    build_model(bg);
    @(negedge clk); i_bg = bg; i_start = 1'b1;
    @(negedge clk); i_start = 1'b0; i_bg = $urandom;
    check("active_rise", 64'(o_active), 64'd1);
    cyc = 0;
    while (!o_done && cyc < 400) begin
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check("access", 64'(observe()), 64'(exp));
      i_start = (cyc == ign_start_cyc);
      @(negedge clk); cyc++;
    end
    i_start = 1'b0;
    cnt8 = 8'(m_cnt);
    check("run_len", 64'(cyc), 64'(m_len));
    check("done_access", 64'(observe()), 64'd0);
    check("done", 64'(o_done), 64'd1);
    check("active_fall", 64'(o_active), 64'd0);
    check("fail", 64'(o_fail), 64'(m_fail));
    check("passed", 64'(o_passed), 64'(!m_fail));
    check("fail_elem", 64'(o_fail_elem), 64'(m_elem));
    check("fail_adr", 64'(o_fail_adr), 64'(m_adr));
    check("fail_port", 64'(o_fail_port), 64'(m_port));
    check("fail_cnt", 64'(o_fail_cnt), 64'(cnt8));
    check("status", 64'(o_status),
          64'({12'd0, m_port, cnt8, m_adr, m_elem, m_fail, 1'b1, 1'b0}));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] bg;
    logic        f0, f1, sa1;
    logic [4:0]  fadr;
    int          fbit;
    logic        e_fail;
    logic [2:0]  e_elem;
    logic [4:0]  e_adr;
    logic        e_port;
    int          e_cnt, e_cnt_stop, e_len_stop;
  } vec_t;
  vec_t tbl[6];

  initial begin
    tbl[0] = '{32'h0000_0000, 0, 0, 0, 5'd0,  0, 0, 3'd0, 5'd0,  0, 0, 0, 321};
    tbl[1] = '{32'hA5A5_A5A5, 0, 0, 0, 5'd0,  0, 0, 3'd0, 5'd0,  0, 0, 0, 321};
    tbl[2] = '{32'h0000_0000, 1, 0, 1, 5'd5,  7, 1, 3'd1, 5'd5,  0, 3, 1, 44};
    tbl[3] = '{32'h0000_0000, 1, 1, 0, 5'd31, 0, 1, 3'd2, 5'd31, 0, 4, 2, 160};
    tbl[4] = '{32'h0000_0000, 0, 1, 0, 5'd31, 0, 1, 3'd2, 5'd31, 1, 2, 1, 160};
    tbl[5] = '{32'hFFFF_FFFF, 0, 1, 1, 5'd0,  3, 1, 3'd2, 5'd0,  1, 2, 1, 98};

    reset = 1'b1; i_start = 1'b0; i_bg = '0;
    f0_en = 1'b0; f1_en = 1'b0; f_sa1 = 1'b0; f_adr = '0; f_bit = 0;
    repeat (3) @(negedge clk);
    check("rst_active", 64'(o_active), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    check("rst_fail", 64'(o_fail), 64'd0);
    check("rst_passed", 64'(o_passed), 64'd0);
    check("rst_cnt", 64'(o_fail_cnt), 64'd0);
    check("rst_status", 64'(o_status), 64'd0);
    check("rst_access", 64'(observe()), 64'd0);
    check("rst_state", 64'(o_dbg_state), 64'(S_IDLE));
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      f0_en = tbl[i].f0; f1_en = tbl[i].f1; f_sa1 = tbl[i].sa1;
      f_adr = tbl[i].fadr; f_bit = tbl[i].fbit;
      run(tbl[i].bg, (i == 0) ? 100 : -1);
      check("tbl_fail", 64'(o_fail), 64'(tbl[i].e_fail));
      check("tbl_elem", 64'(o_fail_elem), 64'(tbl[i].e_elem));
      check("tbl_adr", 64'(o_fail_adr), 64'(tbl[i].e_adr));
      check("tbl_port", 64'(o_fail_port), 64'(tbl[i].e_port));
`ifdef RA_BIST_STOP_ON_FAIL_EN
      check("tbl_cnt", 64'(o_fail_cnt), 64'(tbl[i].e_cnt_stop));
      check("tbl_len", 64'(m_len), 64'(tbl[i].e_len_stop));
`else
      check("tbl_cnt", 64'(o_fail_cnt), 64'(tbl[i].e_cnt));
      check("tbl_len", 64'(m_len), 64'd321);
`endif
    end

    // reset in the middle of M2, then a clean run
`ifdef RA_BIST_STOP_ON_FAIL_EN
    f0_en = 1'b0; f1_en = 1'b0;
`else
    f0_en = 1'b1; f1_en = 1'b0; f_sa1 = 1'b1; f_adr = 5'd5; f_bit = 7;
`endif
    @(negedge clk); i_bg = 32'h0; i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    repeat (110) @(negedge clk);
    check("mid_state_m2", 64'(o_dbg_state), 64'(S_M2));
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_active", 64'(o_active), 64'd0);
    check("mid_rst_access", 64'(observe()), 64'd0);
    check("mid_rst_done", 64'(o_done), 64'd0);
    check("mid_rst_fail", 64'(o_fail), 64'd0);
    check("mid_rst_cnt", 64'(o_fail_cnt), 64'd0);
    reset = 1'b0;
    f0_en = 1'b0; f1_en = 1'b0;
    run($urandom, 50);

    // randomized fault configurations
    for (int r = 0; r < 6; r++) begin
      f0_en = 1'($urandom_range(0, 1));
      f1_en = 1'($urandom_range(0, 1));
      f_sa1 = 1'($urandom_range(0, 1));
      f_adr = 5'($urandom_range(0, 31));
      f_bit = $urandom_range(0, 31);
      run($urandom, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
